// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM encoding, winner codes and screen/paddle geometry
// used by the game controller as well as the paddle and ball rendering blocks.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int BALL_SIZE = 8;
    localparam int PAD_W     = 10;
    localparam int PAD_H     = 80;
    localparam int P1_X      = 50;
    localparam int P2_X      = 590;

endpackage

// File: rtl/pong_collide.sv
// Combinational per-frame ball step: wall bounces, paddle bounces and miss
// detection from the current position, direction and paddle rows.
module pong_collide
    import pong_pkg::*;
#(
    parameter int SPEED = 2
) (
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       vx_neg,
    input  logic       vy_neg,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_y,
    output logic [9:0] next_x,
    output logic [9:0] next_y,
    output logic       next_vx_neg,
    output logic       next_vy_neg,
    output logic       p1_point,
    output logic       p2_point
);

    localparam logic signed [11:0] STEP     = 12'(SPEED);
    localparam logic signed [11:0] BALL     = 12'(BALL_SIZE);
    localparam logic signed [11:0] Y_MAX    = 12'(V_RES - BALL_SIZE);
    localparam logic signed [11:0] X_LIMIT  = 12'(H_RES);
    localparam logic signed [11:0] P1_LEFT  = 12'(P1_X);
    localparam logic signed [11:0] P1_RIGHT = 12'(P1_X + PAD_W);
    localparam logic signed [11:0] P2_LEFT  = 12'(P2_X);
    localparam logic signed [11:0] P2_RIGHT = 12'(P2_X + PAD_W);
    localparam logic signed [11:0] PAD_LEN  = 12'(PAD_H);
    localparam logic signed [11:0] ZERO     = 12'sd0;

    logic signed [11:0] vx, vy, nx, ny, pad1, pad2;
    logic               overlap1, overlap2;

    // 12-bit signed arithmetic so a step past the top or left edge goes negative
    assign vx       = vx_neg ? -STEP : STEP;
    assign vy       = vy_neg ? -STEP : STEP;
    assign nx       = $signed({2'b00, ball_x}) + vx;
    assign ny       = $signed({2'b00, ball_y}) + vy;
    assign pad1     = $signed({2'b00, p1_y});
    assign pad2     = $signed({2'b00, p2_y});
    assign overlap1 = (ny + BALL > pad1) && (ny < pad1 + PAD_LEN);
    assign overlap2 = (ny + BALL > pad2) && (ny < pad2 + PAD_LEN);

    always_comb begin
        next_x      = ball_x;
        next_y      = ny[9:0];
        next_vx_neg = vx_neg;
        next_vy_neg = vy_neg;
        p1_point    = 1'b0;
        p2_point    = 1'b0;

        if (ny <= ZERO) begin
            next_y      = 10'd0;
            next_vy_neg = 1'b0;
        end else if (ny >= Y_MAX) begin
            next_y      = 10'(V_RES - BALL_SIZE);
            next_vy_neg = 1'b1;
        end

        // Paddle hits take priority over misses so a ball clipping a paddle edge survives
        if (vx_neg && (nx <= P1_RIGHT) && (nx + BALL > P1_LEFT) && overlap1) begin
            next_x      = 10'(P1_X + PAD_W);
            next_vx_neg = 1'b0;
        end else if (!vx_neg && (nx + BALL >= P2_LEFT) && (nx < P2_RIGHT) && overlap2) begin
            next_x      = 10'(P2_X - BALL_SIZE);
            next_vx_neg = 1'b1;
        end else if (nx <= ZERO) begin
            p2_point = 1'b1;
        end else if (nx + BALL >= X_LIMIT) begin
            p1_point = 1'b1;
        end else begin
            next_x = nx[9:0];
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: idle/serve/play/point/game-over FSM, scores and the
// registered ball state, all advancing only on the frame tick.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [2:0] game_state,
    output logic       point_pulse,
    output logic [1:0] winner
);

    localparam int               CNT_W      = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [3:0]       WIN_MAX    = 4'(WIN_SCORE);
    localparam logic [9:0]       X_CENTRE   = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0]       Y_CENTRE   = 10'((V_RES - BALL_SIZE) / 2);

    state_t           state, state_next;
    logic [9:0]       x_next, y_next;
    logic             vx_neg, vy_neg, vx_neg_next, vy_neg_next;
    logic [3:0]       s1_next, s2_next;
    logic             pulse_next;
    logic [1:0]       winner_next;
    logic [CNT_W-1:0] serve_cnt, cnt_next;
    logic             p1_scored, p1_scored_next;

    logic [9:0] col_x, col_y;
    logic       col_vx_neg, col_vy_neg, col_p1_point, col_p2_point;

    pong_collide #(
        .SPEED(SPEED)
    ) u_collide (
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .vx_neg     (vx_neg),
        .vy_neg     (vy_neg),
        .p1_y       (p1_y),
        .p2_y       (p2_y),
        .next_x     (col_x),
        .next_y     (col_y),
        .next_vx_neg(col_vx_neg),
        .next_vy_neg(col_vy_neg),
        .p1_point   (col_p1_point),
        .p2_point   (col_p2_point)
    );

    assign game_state = state;

    always_comb begin
        state_next     = state;
        x_next         = ball_x;
        y_next         = ball_y;
        vx_neg_next    = vx_neg;
        vy_neg_next    = vy_neg;
        s1_next        = score_p1;
        s2_next        = score_p2;
        pulse_next     = 1'b0;
        winner_next    = winner;
        cnt_next       = serve_cnt;
        p1_scored_next = p1_scored;

        case (state)
            ST_IDLE, ST_GAMEOVER: begin
                if (start_btn) begin
                    state_next  = ST_SERVE;
                    x_next      = X_CENTRE;
                    y_next      = Y_CENTRE;
                    vx_neg_next = 1'b0;
                    vy_neg_next = 1'b0;
                    s1_next     = '0;
                    s2_next     = '0;
                    winner_next = WIN_NONE;
                    cnt_next    = '0;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (serve_cnt == SERVE_LAST) begin
                        state_next = ST_PLAY;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = serve_cnt + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (col_p1_point || col_p2_point) begin
                        // Recentre and serve toward whoever just conceded
                        state_next     = ST_POINT;
                        pulse_next     = 1'b1;
                        x_next         = X_CENTRE;
                        y_next         = Y_CENTRE;
                        vx_neg_next    = col_p2_point;
                        p1_scored_next = col_p1_point;
                        if (col_p1_point && score_p1 < WIN_MAX) s1_next = score_p1 + 4'd1;
                        if (col_p2_point && score_p2 < WIN_MAX) s2_next = score_p2 + 4'd1;
                    end else begin
                        x_next      = col_x;
                        y_next      = col_y;
                        vx_neg_next = col_vx_neg;
                        vy_neg_next = col_vy_neg;
                    end
                end
            end
            ST_POINT: begin
                if (p1_scored ? (score_p1 == WIN_MAX) : (score_p2 == WIN_MAX)) begin
                    state_next  = ST_GAMEOVER;
                    winner_next = p1_scored ? WIN_P1 : WIN_P2;
                end else begin
                    state_next = ST_SERVE;
                    cnt_next   = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            ball_x      <= X_CENTRE;
            ball_y      <= Y_CENTRE;
            vx_neg      <= 1'b0;
            vy_neg      <= 1'b0;
            score_p1    <= '0;
            score_p2    <= '0;
            point_pulse <= 1'b0;
            winner      <= WIN_NONE;
            serve_cnt   <= '0;
            p1_scored   <= 1'b0;
        end else begin
            state       <= state_next;
            ball_x      <= x_next;
            ball_y      <= y_next;
            vx_neg      <= vx_neg_next;
            vy_neg      <= vy_neg_next;
            score_p1    <= s1_next;
            score_p2    <= s2_next;
            point_pulse <= pulse_next;
            winner      <= winner_next;
            serve_cnt   <= cnt_next;
            p1_scored   <= p1_scored_next;
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: an integer game model compared every
// cycle, plus hand-computed trajectory and scoring checkpoints.
module tb_pong_game_ctrl;

    localparam int SPD    = 2;
    localparam int HRES   = 640;
    localparam int VRES   = 480;
    localparam int BALL   = 8;
    localparam int PADW   = 10;
    localparam int PADH   = 80;
    localparam int P1X    = 50;
    localparam int P2X    = 590;
    localparam int FRAMES = 60;
    localparam int WIN    = 7;
    localparam int CX     = (HRES - BALL) / 2;
    localparam int CY     = (VRES - BALL) / 2;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic [9:0] p1_y = '0;
    logic [9:0] p2_y = '0;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score_p1, score_p2;
    logic [2:0] game_state;
    logic       point_pulse;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;
    bit checkEnable = 0;
    bit p1Track = 1;
    bit p2Track = 1;

    int mx, my, mvx, mvy, mstate, ms1, ms2, mwin, mpulse, mcnt, mscorer;

    pong_game_ctrl dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .p1_y       (p1_y),
        .p2_y       (p2_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .game_state (game_state),
        .point_pulse(point_pulse),
        .winner     (winner)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        mx = CX; my = CY; mvx = SPD; mvy = SPD;
        mstate = 0; ms1 = 0; ms2 = 0; mwin = 0; mpulse = 0; mcnt = 0; mscorer = 0;
    endfunction

    function automatic bit overlaps(int ny, int py);
        return (ny + BALL > py) && (ny < py + PADH);
    endfunction

    function automatic void modelScore(int who);
        if (who == 1 && ms1 < WIN) ms1++;
        if (who == 2 && ms2 < WIN) ms2++;
        mvx = (who == 2) ? -SPD : SPD;
        mx = CX; my = CY;
        mstate = 3; mpulse = 1; mscorer = who;
    endfunction

    function automatic void modelFrame();
        int nx = mx + mvx;
        int ny = my + mvy;
        int ty = ny;
        int tvy = mvy;
        if (ny <= 0) begin
            ty = 0; tvy = SPD;
        end else if (ny >= VRES - BALL) begin
            ty = VRES - BALL; tvy = -SPD;
        end
        if (mvx < 0 && nx <= P1X + PADW && nx + BALL > P1X && overlaps(ny, int'(p1_y))) begin
            mx = P1X + PADW; mvx = SPD; my = ty; mvy = tvy;
        end else if (mvx > 0 && nx + BALL >= P2X && nx < P2X + PADW && overlaps(ny, int'(p2_y))) begin
            mx = P2X - BALL; mvx = -SPD; my = ty; mvy = tvy;
        end else if (nx <= 0) begin
            modelScore(2);
        end else if (nx + BALL >= HRES) begin
            modelScore(1);
        end else begin
            mx = nx; my = ty; mvy = tvy;
        end
    endfunction

    function automatic void modelStep();
        mpulse = 0;
        case (mstate)
            0, 4: if (start_btn) begin
                mstate = 1; ms1 = 0; ms2 = 0; mwin = 0;
                mvx = SPD; mvy = SPD; mcnt = 0; mx = CX; my = CY;
            end
            1: if (frame_tick) begin
                if (mcnt == FRAMES - 1) begin
                    mstate = 2; mcnt = 0;
                end else begin
                    mcnt++;
                end
            end
            2: if (frame_tick) modelFrame();
            3: begin
                if ((mscorer == 1 && ms1 == WIN) || (mscorer == 2 && ms2 == WIN)) begin
                    mstate = 4; mwin = mscorer;
                end else begin
                    mstate = 1; mcnt = 0;
                end
            end
            default: mstate = 0;
        endcase
    endfunction

    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) modelReset();
        else modelStep();
    end

    always @(negedge vga_clk) begin
        if (checkEnable) begin
            checkOutput("cyc_state", int'(game_state), mstate);
            checkOutput("cyc_ball_x", int'(ball_x), mx);
            checkOutput("cyc_ball_y", int'(ball_y), my);
            checkOutput("cyc_score_p1", int'(score_p1), ms1);
            checkOutput("cyc_score_p2", int'(score_p2), ms2);
            checkOutput("cyc_pulse", int'(point_pulse), mpulse);
            checkOutput("cyc_winner", int'(winner), mwin);
        end
    end

    function automatic logic [9:0] trackRow(int y);
        int p = y - 36;
        if (p < 0) p = 0;
        if (p > VRES - PADH) p = VRES - PADH;
        return 10'(p);
    endfunction

    function automatic logic [9:0] awayRow(int y);
        return (y < CY) ? 10'd400 : 10'd0;
    endfunction

    task automatic cycle();
        @(posedge vga_clk);
        #1;
        p1_y = p1Track ? trackRow(my) : awayRow(my);
        p2_y = p2Track ? trackRow(my) : awayRow(my);
    endtask

    task automatic applyStimulus(input bit tick, input bit start);
        frame_tick = tick;
        start_btn  = start;
        cycle();
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        repeat (2) cycle();
    endtask

    // Leaves the bench on the cycle where the point has just been registered
    task automatic waitPoint(input string tag);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 3000) begin
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
            n++;
            if (mstate == 3) seen = 1;
            else repeat (2) cycle();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=no_point required=point within %0d ticks", tag, n);
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        repeat (2) @(posedge vga_clk);
        #1;
        checkEnable = 1;
        checkOutput("rst_state", int'(game_state), 0);
        checkOutput("rst_ball_x", int'(ball_x), 316);
        checkOutput("rst_ball_y", int'(ball_y), 236);
        checkOutput("rst_score_p1", int'(score_p1), 0);
        checkOutput("rst_winner", int'(winner), 0);
        reset_n = 1'b1;
        repeat (2) cycle();

        applyStimulus(1, 0);
        checkOutput("idle_ignores_tick", int'(game_state), 0);
        applyStimulus(0, 1);
        checkOutput("start_to_serve", int'(game_state), 1);
        repeat (59) applyStimulus(1, 0);
        checkOutput("serve_59_ticks", int'(game_state), 1);
        checkOutput("serve_ball_held", int'(ball_x), 316);
        applyStimulus(1, 0);
        checkOutput("serve_to_play", int'(game_state), 2);
        checkOutput("play_entry_x", int'(ball_x), 316);
        checkOutput("play_entry_y", int'(ball_y), 236);
        applyStimulus(1, 0);
        checkOutput("first_move_x", int'(ball_x), 318);
        checkOutput("first_move_y", int'(ball_y), 238);

        repeat (117) applyStimulus(1, 0);
        checkOutput("bottom_clamp_y", int'(ball_y), 472);
        checkOutput("bottom_clamp_x", int'(ball_x), 552);
        applyStimulus(1, 0);
        checkOutput("bottom_bounce_y", int'(ball_y), 470);
        repeat (14) applyStimulus(1, 0);
        checkOutput("right_paddle_x", int'(ball_x), 582);
        repeat (261) applyStimulus(1, 0);
        checkOutput("left_paddle_x", int'(ball_x), 60);
        checkOutput("left_paddle_y", int'(ball_y), 80);
        applyStimulus(1, 0);
        checkOutput("left_bounce_x", int'(ball_x), 62);

        p1Track = 0;
        waitPoint("left_miss");
        checkOutput("miss_state", int'(game_state), 3);
        checkOutput("miss_pulse", int'(point_pulse), 1);
        checkOutput("miss_score_p2", int'(score_p2), 1);
        checkOutput("miss_score_p1", int'(score_p1), 0);
        checkOutput("miss_recentre_x", int'(ball_x), 316);
        checkOutput("miss_recentre_y", int'(ball_y), 236);
        cycle();
        checkOutput("point_to_serve", int'(game_state), 1);
        checkOutput("pulse_one_cycle", int'(point_pulse), 0);
        repeat (2) cycle();
        repeat (60) applyStimulus(1, 0);
        applyStimulus(1, 0);
        checkOutput("serve_toward_p1_x", int'(ball_x), 314);

        p1Track = 1;
        p2Track = 0;
        for (int pt = 1; pt <= WIN; pt++) begin
            waitPoint("right_miss");
            checkOutput("p1_score_step", int'(score_p1), pt);
            checkOutput("p1_pulse_step", int'(point_pulse), 1);
            cycle();
            if (pt < WIN) begin
                repeat (2) cycle();
                repeat (60) applyStimulus(1, 0);
            end
        end
        checkOutput("gameover_state", int'(game_state), 4);
        checkOutput("gameover_winner", int'(winner), 1);
        checkOutput("gameover_score_p1", int'(score_p1), 7);
        checkOutput("gameover_score_p2", int'(score_p2), 1);
        repeat (2) cycle();
        repeat (5) applyStimulus(1, 0);
        checkOutput("frozen_state", int'(game_state), 4);
        checkOutput("frozen_ball_x", int'(ball_x), 316);
        checkOutput("frozen_score_p1", int'(score_p1), 7);
        applyStimulus(0, 1);
        checkOutput("restart_state", int'(game_state), 1);
        checkOutput("restart_score_p1", int'(score_p1), 0);
        checkOutput("restart_score_p2", int'(score_p2), 0);
        checkOutput("restart_winner", int'(winner), 0);

        p2Track = 1;
        repeat (60) applyStimulus(1, 0);
        repeat (5) applyStimulus(1, 0);
        checkOutput("replay_state", int'(game_state), 2);
        checkOutput("replay_x", int'(ball_x), 326);
        checkOutput("replay_y", int'(ball_y), 246);

        @(posedge vga_clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_state", int'(game_state), 0);
        checkOutput("async_rst_x", int'(ball_x), 316);
        checkOutput("async_rst_y", int'(ball_y), 236);
        checkOutput("async_rst_score", int'(score_p1), 0);
        checkOutput("async_rst_pulse", int'(point_pulse), 0);
        #10;
        reset_n = 1'b1;
        repeat (2) cycle();
        checkOutput("post_rst_idle", int'(game_state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
